// File: rtl/paddle_step_scheduler.sv
// paddle_step_scheduler
//   Moves the two Pong paddles from their button requests. One shared
//   step-delay timer is arbitrated round-robin between the paddles. Each
//   move is followed by DELAY_CYCLES cycles of dead time. The block owns
//   both paddle Y registers and clamps them to the visible field.
//
// Ports
//   CLK_100MHz  system clock
//   Reset_n     asynchronous active-low reset
//   Enable      gates new grants only; a move/delay already started completes
//   BtnUp[1:0]  up request per paddle   (bit 0 = left, bit 1 = right)
//   BtnDown[1:0] down request per paddle (same mapping)
//   PaddleY0    top line of the left paddle
//   PaddleY1    top line of the right paddle
//   Grant[1:0]  paddle(s) being moved, asserted in SMOVE only
//   Busy        high in SMOVE and SDELAY
//
// Build option
//   PADDLE_DUAL_GRANT_EN: when both paddles request together, move both in
//   the same SMOVE cycle (Grant=2'b11) and leave the round-robin pointer as is.
module paddle_step_scheduler #(
    parameter int Y_W          = 10,
    parameter int SCREEN_H     = 480,
    parameter int PADDLE_H     = 64,
    parameter int STEP         = 4,
    parameter int DELAY_CYCLES = 1000000
) (
    input  logic           CLK_100MHz,
    input  logic           Reset_n,
    input  logic           Enable,
    input  logic [1:0]     BtnUp,
    input  logic [1:0]     BtnDown,
    output logic [Y_W-1:0] PaddleY0,
    output logic [Y_W-1:0] PaddleY1,
    output logic [1:0]     Grant,
    output logic           Busy
);

    localparam int Y_MAX = SCREEN_H - PADDLE_H;
    localparam int Y_MID = Y_MAX / 2;
    localparam int CNT_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

    typedef enum logic [1:0] {SIDLE, SMOVE, SDELAY} state_t;

    state_t           state, state_next;
    logic [1:0]       req;
    logic [1:0]       pick;
    logic [1:0]       sel, sel_next;       // paddle mask latched for SMOVE
    logic [1:0]       dir_up, dir_up_next; // per-paddle direction, 1 = up
    logic             ptr;                 // paddle that wins a tie next
    logic [CNT_W-1:0] cnt;
    logic [Y_W-1:0]   y [2];

    // Up clamps at 0; down sums one bit wider so Y+STEP can't wrap.
    function automatic logic [Y_W-1:0] step_y(input logic [Y_W-1:0] cur,
                                              input logic up);
        logic [Y_W:0] sum;
        sum = {1'b0, cur} + (Y_W+1)'(STEP);
        if (up)
            step_y = (cur < Y_W'(STEP)) ? '0 : cur - Y_W'(STEP);
        else
            step_y = (sum > (Y_W+1)'(Y_MAX)) ? Y_W'(Y_MAX) : sum[Y_W-1:0];
    endfunction

    // Both buttons together cancel out.
    assign req = BtnUp ^ BtnDown;

    always_comb begin
        pick = req;
        if (&req) begin
`ifdef PADDLE_DUAL_GRANT_EN
            pick = 2'b11;
`else
            pick = ptr ? 2'b10 : 2'b01;
`endif
        end
    end

    always_ff @(posedge CLK_100MHz or negedge Reset_n) begin
        if (!Reset_n) state <= SIDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next  = state;
        sel_next    = sel;
        dir_up_next = dir_up;
        Grant       = 2'b00;
        Busy        = 1'b1;
        case (state)
            SIDLE: begin
                Busy = 1'b0;
                if (Enable && (|req)) begin
                    state_next  = SMOVE;
                    sel_next    = pick;
                    dir_up_next = BtnUp;
                end
            end
            SMOVE: begin
                Grant      = sel;
                state_next = SDELAY;
            end
            SDELAY: begin
                if (cnt == '0) state_next = SIDLE;
            end
            default: state_next = SIDLE;
        endcase
    end

    always_ff @(posedge CLK_100MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            sel    <= 2'b00;
            dir_up <= 2'b00;
            ptr    <= 1'b0;
            cnt    <= '0;
            y[0]   <= Y_W'(Y_MID);
            y[1]   <= Y_W'(Y_MID);
        end else begin
            sel    <= sel_next;
            dir_up <= dir_up_next;
            if (state == SMOVE) begin
                for (int i = 0; i < 2; i++)
                    if (sel[i]) y[i] <= step_y(y[i], dir_up[i]);
                // A single grant hands priority to the other paddle
                // (granted index ^ 1 == sel[0]); a dual grant leaves it.
                if (sel != 2'b11) ptr <= sel[0];
                // SMOVE loads N-1 and SDELAY exits on 0: N cycles of dwell.
                cnt <= CNT_W'(DELAY_CYCLES - 1);
            end else if (state == SDELAY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign PaddleY0 = y[0];
    assign PaddleY1 = y[1];

endmodule

// File: tb/tb_paddle_step_scheduler.sv
// Bench for paddle_step_scheduler with a short step delay. Expected grants
// and resulting positions are queued as stimulus is applied and compared
// when the DUT asserts Grant.
module tb_paddle_step_scheduler;

    localparam int D    = 4;
    localparam int PER  = D + 2;
    localparam int YMAX = 416;
    localparam int YMID = 208;
`ifdef PADDLE_DUAL_GRANT_EN
    localparam int DUAL = 1;
`else
    localparam int DUAL = 0;
`endif

    typedef struct {
        logic [1:0] g;
        int         y0;
        int         y1;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic [1:0] up = 2'b00;
    logic [1:0] dn = 2'b00;
    logic [9:0] y0, y1;
    logic [1:0] grant;
    logic       busy;

    paddle_step_scheduler #(
        .Y_W(10), .SCREEN_H(480), .PADDLE_H(64), .STEP(4), .DELAY_CYCLES(D)
    ) dut (
        .CLK_100MHz(clk), .Reset_n(rst_n), .Enable(en),
        .BtnUp(up), .BtnDown(dn),
        .PaddleY0(y0), .PaddleY1(y1), .Grant(grant), .Busy(busy)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    ent_t sb[$];
    int   y0m = YMID, y1m = YMID;
    logic ptrm = 1'b0;
    int   cyc = 0, last_cyc = -1, run = 0;
    logic ychk = 1'b0;
    ent_t cur;

    function automatic int mv(input int y, input logic u);
        if (u) return (y < 4) ? 0 : y - 4;
        return (y + 4 > YMAX) ? YMAX : y + 4;
    endfunction

    // Queue the grant the held buttons should produce next.
    task automatic push_grant(input logic [1:0] u, input logic [1:0] d);
        logic [1:0] r, s;
        ent_t e;
        r = u ^ d;
        if (r == 2'b11) s = DUAL ? 2'b11 : (ptrm ? 2'b10 : 2'b01);
        else            s = r;
        if (s[0]) y0m = mv(y0m, u[0]);
        if (s[1]) y1m = mv(y1m, u[1]);
        if (s != 2'b11) ptrm = s[0];
        e.g = s; e.y0 = y0m; e.y1 = y1m;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            run  = 0;
            ychk = 1'b0;
        end else begin
            if (ychk) begin
                chk("y0_after_move", y0, cur.y0);
                chk("y1_after_move", y1, cur.y1);
                ychk = 1'b0;
            end
            if (busy) run++;
            else if (run != 0) begin
                chk("busy_len", run, PER - 1);
                run = 0;
            end
            if (grant != 2'b00) begin
                if (sb.size() == 0) chk("unexpected_grant", grant, 0);
                else begin
                    cur = sb.pop_front();
                    chk("grant", grant, cur.g);
                    ychk = 1'b1;
                    if (last_cyc >= 0) chk("grant_period", cyc - last_cyc, PER);
                    last_cyc = cyc;
                end
            end
        end
    end

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle", busy, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_y0", y0, YMID);
        chk("rst_y1", y1, YMID);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        y0m = YMID; y1m = YMID; ptrm = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_hold(input logic [1:0] u, input logic [1:0] d, input int n);
        last_cyc = -1;
        for (int k = 0; k < n; k++) push_grant(u, d);
        @(negedge clk);
        up = u; dn = d;
        wait_drain(n * PER + 10);
        up = 2'b00; dn = 2'b00;
        wait_idle(2 * PER);
        chk("y0_end", y0, y0m);
        chk("y1_end", y1, y1m);
    endtask

    task automatic watch_quiet(input string tag, input int n);
        logic seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        // left paddle up, right untouched
        run_hold(2'b01, 2'b00, 3);
        // both up: alternate (or dual) grants from a fresh pointer
        do_reset();
        run_hold(2'b11, 2'b00, DUAL ? 4 : 4);
        // right paddle down into the bottom clamp and beyond
        run_hold(2'b00, 2'b10, (YMAX - y1m) / 4 + 2);
        // left paddle up into the top clamp and beyond
        run_hold(2'b01, 2'b00, y0m / 4 + 2);
        chk("y0_top", y0, 0);
        chk("y1_bottom", y1, YMAX);

        // conflicting buttons: no request
        @(negedge clk);
        up = 2'b01; dn = 2'b01;
        watch_quiet("no_busy_conflict", 20);
        up = 2'b00; dn = 2'b00;
        // Enable low: no grants
        en = 1'b0; up = 2'b11;
        watch_quiet("no_busy_disabled", 20);
        up = 2'b00; en = 1'b1;

        // Enable dropped during the delay: delay finishes, no regrant
        last_cyc = -1;
        push_grant(2'b00, 2'b01);
        @(negedge clk);
        dn = 2'b01;
        wait_drain(PER + 10);
        en = 1'b0;
        wait_idle(2 * PER);
        watch_quiet("no_regrant_disabled", PER);
        dn = 2'b00; en = 1'b1;
        chk("y0_en_drop", y0, y0m);

        // reset in the middle of SDELAY
        last_cyc = -1;
        push_grant(2'b00, 2'b10);
        @(negedge clk);
        dn = 2'b10;
        wait_drain(PER + 10);
        dn = 2'b00;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_grant", grant, 0);
        chk("midrst_y0", y0, YMID);
        chk("midrst_y1", y1, YMID);
        y0m = YMID; y1m = YMID; ptrm = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // opposite directions on both paddles
        run_hold(2'b01, 2'b10, DUAL ? 1 : 2);
        chk("y0_final", y0, 204);
        chk("y1_final", y1, 212);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
